// File: rtl/sram_ctrl_512k8.sv
// Controller for an asynchronous 512K x 8 SRAM: one request at a time, every pin driven from a flop,
// and at least one idle cycle between transactions so the data bus can turn around cleanly.
module sram_ctrl_512k8 #(
  parameter int unsigned READ_WAIT   = 2,
  parameter int unsigned WRITE_PULSE = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [18:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [18:0] sram_a,
  inout  wire  [7:0]  sram_dq,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_WAIT  = 3'd1,
    S_RD_DONE  = 3'd2,
    S_WR_SETUP = 3'd3,
    S_WR_PULSE = 3'd4,
    S_WR_HOLD  = 3'd5
  } state_t;

  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_PULSE - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_accept;
  logic        w_sample;
  logic        w_ce_n_nxt;
  logic        w_oe_n_nxt;
  logic        w_we_n_nxt;
  logic        w_dq_oe_nxt;

  logic        r_ready;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_rdata;
  logic [18:0] r_a;
  logic [7:0]  r_wdata;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_dq_oe;

  // Next-state, phase counter and pin levels; pins are decoded from the next state so the flops
  // below present them in the same cycle the FSM enters that state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 4'd0;
        if (req_valid) begin
          w_accept = 1'b1;
          if (req_we) begin
            w_state_nxt = S_WR_SETUP;
          end else begin
            w_state_nxt = S_RD_WAIT;
            w_cnt_nxt   = RD_LOAD;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_sample    = 1'b1;
          w_state_nxt = S_RD_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RD_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_WR_SETUP: begin
        w_state_nxt = S_WR_PULSE;
        w_cnt_nxt   = WR_LOAD;
      end
      S_WR_PULSE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_WR_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_WR_HOLD: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase

    w_ce_n_nxt  = 1'b1;
    w_oe_n_nxt  = 1'b1;
    w_we_n_nxt  = 1'b1;
    w_dq_oe_nxt = 1'b0;
    case (w_state_nxt)
      S_RD_WAIT: begin
        w_ce_n_nxt = 1'b0;
        w_oe_n_nxt = 1'b0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        w_ce_n_nxt  = 1'b0;
        w_dq_oe_nxt = 1'b1;
      end
      S_WR_PULSE: begin
        w_ce_n_nxt  = 1'b0;
        w_we_n_nxt  = 1'b0;
        w_dq_oe_nxt = 1'b1;
      end
      default: begin
        w_ce_n_nxt  = 1'b1;
        w_dq_oe_nxt = 1'b0;
      end
    endcase
  end

  // FSM state and phase counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered handshake, response and SRAM pin drivers; address only loads while the chip is deselected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_a         <= 19'd0;
      r_wdata     <= 8'h00;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
    end else begin
      r_ready     <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RD_DONE);
      r_ce_n      <= w_ce_n_nxt;
      r_oe_n      <= w_oe_n_nxt;
      r_we_n      <= w_we_n_nxt;
      r_dq_oe     <= w_dq_oe_nxt;
      if (w_accept) begin
        r_a     <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_sample) begin
        r_rsp_rdata <= sram_dq;
      end
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign sram_a    = r_a;
  assign sram_ce_n = r_ce_n;
  assign sram_oe_n = r_oe_n;
  assign sram_we_n = r_we_n;
  assign sram_dq   = r_dq_oe ? r_wdata : {8{1'bz}};

endmodule

// File: tb/tb_sram_ctrl_512k8.sv
// Directed bench for sram_ctrl_512k8: default-timing instance A and READ_WAIT=4/WRITE_PULSE=1
// instance B, each attached to a simple asynchronous SRAM model.
module tb_sram_ctrl_512k8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_we = 1'b0;
  logic [18:0] req_addr = 19'd0;
  logic [7:0]  req_wdata = 8'd0;
  logic        req_valid_a = 1'b0;
  logic        req_valid_b = 1'b0;

  logic        ready_a, rv_a, ce_n_a, oe_n_a, we_n_a;
  logic        ready_b, rv_b, ce_n_b, oe_n_b, we_n_b;
  logic [7:0]  rdata_a, rdata_b;
  logic [18:0] a_a, a_b;
  wire  [7:0]  dq_a, dq_b;

  logic [7:0] mem_a [0:524287];
  logic [7:0] mem_b [0:524287];

  sram_ctrl_512k8 u_a (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_a), .req_ready(ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_a), .rsp_rdata(rdata_a), .sram_a(a_a), .sram_dq(dq_a),
    .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a), .sram_we_n(we_n_a)
  );

  sram_ctrl_512k8 #(.READ_WAIT(4), .WRITE_PULSE(1)) u_b (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_b), .req_ready(ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_b), .rsp_rdata(rdata_b), .sram_a(a_b), .sram_dq(dq_b),
    .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b), .sram_we_n(we_n_b)
  );

  // SRAM models: latch data on the rising edge of WE_n, drive the bus while selected with OE_n low.
  always @(posedge we_n_a) if (!ce_n_a) mem_a[a_a] = dq_a;
  always @(posedge we_n_b) if (!ce_n_b) mem_b[a_b] = dq_b;
  assign dq_a = (!ce_n_a && !oe_n_a) ? mem_a[a_a] : {8{1'bz}};
  assign dq_b = (!ce_n_b && !oe_n_b) ? mem_b[a_b] : {8{1'bz}};

  typedef struct {
    logic        inst;
    logic        we;
    logic [18:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [7:0] last_rd [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {ce_n, oe_n, we_n, req_ready, rsp_valid}
  function automatic logic [4:0] ctrl(input logic i);
    if (i) return {ce_n_b, oe_n_b, we_n_b, ready_b, rv_b};
    else   return {ce_n_a, oe_n_a, we_n_a, ready_a, rv_a};
  endfunction

  function automatic logic [18:0] addr_of(input logic i);
    return i ? a_b : a_a;
  endfunction

  function automatic logic [7:0] rdata_of(input logic i);
    return i ? rdata_b : rdata_a;
  endfunction

  function automatic logic [7:0] dq_of(input logic i);
    return i ? dq_b : dq_a;
  endfunction

  task automatic set_valid(input logic i, input logic v);
    if (i) req_valid_b = v;
    else   req_valid_a = v;
  endtask

  // One complete transaction, checked cycle by cycle; n=1 is the cycle right after the accepting edge.
  task automatic run_txn(input vec_t v);
    int rw;
    int wp;
    int ncyc;
    logic [4:0] e;
    rw = v.inst ? 4 : 2;
    wp = v.inst ? 1 : 2;
    chk($sformatf("ready_pre inst%0d", v.inst), 32'(ctrl(v.inst)), 32'(5'b11110));
    req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    set_valid(v.inst, 1'b1);
    @(posedge clk); #1;
    set_valid(v.inst, 1'b0);
    ncyc = v.we ? wp + 3 : rw + 2;
    for (int n = 1; n <= ncyc; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (v.we) begin
        if (n == 1 || n == wp + 2) e = 5'b01100;
        else if (n <= wp + 1)      e = 5'b01000;
        else                       e = 5'b11110;
      end else begin
        if (n <= rw)          e = 5'b00100;
        else if (n == rw + 1) e = 5'b11101;
        else                  e = 5'b11110;
      end
      chk($sformatf("ctrl inst%0d we%0d addr%0h n%0d", v.inst, v.we, v.addr, n), 32'(ctrl(v.inst)), 32'(e));
      if (e[4] == 1'b0)
        chk($sformatf("sram_a inst%0d n%0d", v.inst, n), 32'(addr_of(v.inst)), 32'(v.addr));
      if (v.we && n <= wp + 2)
        chk($sformatf("dq_wr inst%0d n%0d", v.inst, n), 32'(dq_of(v.inst)), 32'(v.wdata));
      if (!v.we && n == rw + 1) begin
        chk($sformatf("rdata inst%0d addr%0h", v.inst, v.addr), 32'(rdata_of(v.inst)), 32'(v.exp_rdata));
        last_rd[v.inst] = v.exp_rdata;
      end
    end
    if (v.we)
      chk($sformatf("rdata_hold inst%0d", v.inst), 32'(rdata_of(v.inst)), 32'(last_rd[v.inst]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    logic [4:0] c;
    int oe_rise;
    int setup;
    logic prev_oe;
    logic we_mode;

    tbl[0] = '{1'b0, 1'b1, 19'h00123, 8'hA5, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 19'h00123, 8'h00, 8'hA5};
    tbl[2] = '{1'b0, 1'b1, 19'h40000, 8'h5A, 8'h00};
    tbl[3] = '{1'b0, 1'b0, 19'h40000, 8'h00, 8'h5A};
    tbl[4] = '{1'b1, 1'b1, 19'h7FFFF, 8'hFF, 8'h00};
    tbl[5] = '{1'b1, 1'b0, 19'h7FFFF, 8'h00, 8'hFF};
    tbl[6] = '{1'b1, 1'b1, 19'h00000, 8'h81, 8'h00};
    tbl[7] = '{1'b1, 1'b0, 19'h00000, 8'h00, 8'h81};
    tbl[8] = '{1'b0, 1'b0, 19'h00123, 8'h00, 8'hA5};
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset ctrl inst%0d", i), 32'(ctrl(i[0])), 32'(5'b11110));
      chk($sformatf("reset sram_a inst%0d", i), 32'(addr_of(i[0])), 32'd0);
      chk($sformatf("reset rdata inst%0d", i), 32'(rdata_of(i[0])), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 9; k++) run_txn(tbl[k]);

    // Back-to-back read then write on A with req_valid held high throughout
    run_txn('{1'b0, 1'b1, 19'h00010, 8'h11, 8'h00});
    req_we = 1'b0; req_addr = 19'h00010; req_valid_a = 1'b1;
    oe_rise = -1; setup = -1; prev_oe = 1'b1; we_mode = 1'b0;
    @(posedge clk); #1;
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      c = ctrl(1'b0);
      if (c[0]) chk("b2b read rdata", 32'(rdata_a), 32'h11);
      if (!prev_oe && c[3] && oe_rise < 0) oe_rise = n;
      if (!we_mode && c[1]) begin
        req_we = 1'b1; req_wdata = 8'h3C; we_mode = 1'b1;
      end else if (we_mode && !c[4] && setup < 0) begin
        setup = n; req_valid_a = 1'b0;
        chk("b2b setup dq", 32'(dq_a), 32'h3C);
      end
      prev_oe = c[3];
    end
    req_valid_a = 1'b0;
    last_rd[0] = 8'h11;
    chk("b2b oe_n rise cycle", 32'(oe_rise), 32'd3);
    chk("b2b write setup cycle", 32'(setup), 32'd5);
    chk("b2b idle gap", 32'((setup > 0) && (setup - oe_rise >= 2)), 32'd1);
    run_txn('{1'b0, 1'b0, 19'h00010, 8'h00, 8'h3C});

    // Requests toggling during a read on B are ignored and never stored
    req_we = 1'b0; req_addr = 19'h7FFFF; req_valid_b = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 7; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (n <= 4)      chk($sformatf("ign ctrl n%0d", n), 32'(ctrl(1'b1)), 32'(5'b00100));
      else if (n == 5) chk("ign ctrl done", 32'(ctrl(1'b1)), 32'(5'b11101));
      else             chk($sformatf("ign idle n%0d", n), 32'(ctrl(1'b1)), 32'(5'b11110));
      chk($sformatf("ign sram_a n%0d", n), 32'(a_b), 32'h7FFFF);
      if (n == 5) chk("ign rdata", 32'(rdata_b), 32'hFF);
      req_addr = 19'h55555; req_we = 1'b1; req_wdata = 8'hEE;
      req_valid_b = (n <= 4) && n[0];
    end
    req_valid_b = 1'b0;

    // Reset asserted during WR_PULSE on A aborts the write immediately
    req_we = 1'b1; req_addr = 19'h00200; req_wdata = 8'h77; req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    @(posedge clk); #1;
    chk("abort pre ctrl", 32'(ctrl(1'b0)), 32'(5'b01000));
    reset_n = 1'b0;
    #1;
    chk("abort async ctrl", 32'(ctrl(1'b0)), 32'(5'b11110));
    chk("abort async sram_a", 32'(a_a), 32'd0);
    chk("abort async rdata", 32'(rdata_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      chk($sformatf("abort after n%0d", n), 32'(ctrl(1'b0)), 32'(5'b11110));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_ctrl_512k8.md
SRAM_CTRL_512K8 -- requirements
Module: sram_ctrl_512k8

Interface
REQ-001 The block SHALL have parameter READ_WAIT, default 2, the number of cycles CE_n/OE_n are held low before read data is sampled (legal range 1..15).
REQ-002 The block SHALL have parameter WRITE_PULSE, default 2, the number of cycles WE_n is held low per write (legal range 1..15).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  19  byte address into the 512K x 8 array.
REQ-009 req_wdata  input  8  write data.
REQ-010 rsp_valid  output  1  one-cycle pulse, rsp_rdata valid.
REQ-011 rsp_rdata  output  8  read data; holds its value until the next read completes.
REQ-012 sram_a  output  19  SRAM address pins.
REQ-013 sram_dq  inout  8  SRAM bidirectional data bus.
REQ-014 sram_ce_n, sram_oe_n, sram_we_n  output  1 each  SRAM chip enable, output enable, write enable, all active low.

Function
REQ-015 The FSM SHALL have states IDLE, RD_WAIT, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-016 req_ready SHALL be 1 exactly when state is IDLE; acceptance is req_valid & req_ready at a rising edge.
REQ-017 On acceptance, req_addr SHALL be registered onto sram_a, req_wdata into an internal write register, and the state SHALL go to RD_WAIT (req_we=0) or WR_SETUP (req_we=1).
REQ-018 All sram_* control outputs and sram_a SHALL come directly from flops (no combinational glitches).
REQ-019 Read: in RD_WAIT, ce_n=0, oe_n=0, we_n=1, dq tristated, for READ_WAIT cycles (down-counter); on the last RD_WAIT edge, sram_dq SHALL be sampled into rsp_rdata.
REQ-020 RD_DONE SHALL last 1 cycle with rsp_valid=1, ce_n=1, oe_n=1, then return to IDLE; read latency = READ_WAIT+1 cycles from acceptance edge to rsp_valid.
REQ-021 Write: WR_SETUP (1 cycle): ce_n=0, we_n=1, oe_n=1, dq driven with write data.
REQ-022 WR_PULSE (WRITE_PULSE cycles): ce_n=0, we_n=0, oe_n=1, dq driven.
REQ-023 WR_HOLD (1 cycle): we_n=1, ce_n=0, dq still driven, so data and address are stable across the WE_n rising edge; then IDLE with ce_n=1.
REQ-024 Write occupancy SHALL be WRITE_PULSE+2 cycles; no rsp_valid is generated for writes.
REQ-025 sram_dq SHALL be driven only in WR_SETUP/WR_PULSE/WR_HOLD; oe_n=0 and dq driven SHALL never coexist.
REQ-026 sram_a SHALL not change while ce_n=0.
REQ-027 IDLE SHALL always separate two transactions (≥1 cycle with ce_n=oe_n=we_n=1 and dq tristated), covering read-to-write bus turnaround.
REQ-028 req_valid while not in IDLE SHALL be ignored (not accepted, not stored).

Reset
REQ-029 reset_n=0 SHALL asynchronously force: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0x00, sram_a=0, ce_n=oe_n=we_n=1, dq tristated, counters 0.
REQ-030 Reset asserted mid-transaction SHALL abort it; an aborted write's memory contents are undefined, no rsp_valid SHALL follow.

Verification
REQ-031 Write 0xA5 to 0x00123 (defaults) -> we_n low exactly 2 cycles, dq=0xA5 and sram_a=0x00123 stable from WR_SETUP through WR_HOLD, req_ready low 4 cycles.
REQ-032 Read 0x00123 after REQ-031 -> rsp_valid pulses 3 cycles after acceptance with rsp_rdata=0xA5; dq never driven by controller.
REQ-033 Back-to-back read 0x00010 then write 0x3C to 0x00010 with req_valid held -> ≥1 idle cycle between oe_n rising and dq driven; subsequent read returns 0x3C.
REQ-034 READ_WAIT=4, WRITE_PULSE=1, write then read 0x7FFFF with 0xFF -> we_n low 1 cycle, rsp_valid 5 cycles after acceptance, data 0xFF.
REQ-035 reset_n low during WR_PULSE -> same cycle ce_n=we_n=1, dq high-Z, req_ready=1; no rsp_valid after release.
REQ-036 req_valid toggling during RD_WAIT with different address -> ignored; sram_a unchanged until IDLE.
